// File: rtl/usb_uart_fifo_i40.sv
// usb_uart_fifo_i40: iCE40 USB-serial endpoint wrapper.
// Puts the usb_uart core between two SB_IO pin drivers and adds byte FIFOs
// on both data pipelines, occupancy reporting and an optional drop-on-full
// mode for host-to-device traffic. A synchronised copy of reset_n holds the
// core and the FIFO control in reset until two clean clock edges have passed.

// Bidirectional iCE40 I/O cell, modelled for the simple (unregistered)
// input/output pin types used here.
module SB_IO #(
    parameter logic [5:0] PIN_TYPE = 6'b000000
) (
    inout  wire  PACKAGE_PIN,
    input  logic OUTPUT_ENABLE,
    input  logic D_OUT_0,
    output logic D_IN_0
);
    logic oe_s;

    // Output mode 10 gates the driver with OUTPUT_ENABLE, mode 01 always drives.
    always_comb begin
        oe_s = 1'b0;
        if (PIN_TYPE[5:4] == 2'b10) begin
            oe_s = OUTPUT_ENABLE;
        end else if (PIN_TYPE[5:4] == 2'b01) begin
            oe_s = 1'b1;
        end else begin
            oe_s = 1'b0;
        end
    end

    assign PACKAGE_PIN = oe_s ? D_OUT_0 : 1'bz;
    assign D_IN_0      = PACKAGE_PIN;
endmodule

// Idle endpoint with the usb_uart core interface so this block elaborates on
// its own; the production core of the same name takes its place in the full
// build. It never transmits and never moves data.
module usb_uart (
    input  logic        clk_48mhz,
    input  logic        reset,
    output logic        usb_p_tx,
    output logic        usb_n_tx,
    input  logic        usb_p_rx,
    input  logic        usb_n_rx,
    output logic        usb_tx_en,
    input  logic [7:0]  uart_in_data,
    input  logic        uart_in_valid,
    output logic        uart_in_ready,
    output logic [7:0]  uart_out_data,
    output logic        uart_out_valid,
    input  logic        uart_out_ready,
    output logic [11:0] debug
);
    assign usb_p_tx       = 1'b1;
    assign usb_n_tx       = 1'b0;
    assign usb_tx_en      = 1'b0;
    assign uart_in_ready  = 1'b0;
    assign uart_out_data  = 8'h00;
    assign uart_out_valid = 1'b0;

    // Capture line state and handshake inputs onto the debug bus.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            debug <= 12'h000;
        end else begin
            debug <= {usb_p_rx, usb_n_rx, uart_in_valid, uart_out_ready, uart_in_data};
        end
    end
endmodule

// Byte FIFO with registered flags and a registered head byte. A byte pushed at
// one edge appears at the head after that edge; there is no empty bypass.
module usb_uart_fifo_i40_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          srst,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    output logic          wr_ready,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [LW-1:0] level
);
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_nxt_s;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [LW-1:0] level_r;
    logic [LW-1:0] level_nxt_s;
    logic          wr_ready_r;
    logic          rd_valid_r;
    logic [7:0]    head_r;
    logic [7:0]    head_nxt_s;
    logic          push_s;
    logic          pop_s;

    // Flags are registered and both are low during reset, so neither side
    // can transfer while the block is held.
    assign push_s = wr_valid & wr_ready_r;
    assign pop_s  = rd_ready & rd_valid_r;

    // Next pointers, occupancy and the byte that will sit at the head.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        head_nxt_s   = 8'h00;
        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + AW'(1'b1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1'b1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        level_nxt_s = level_r + LW'(push_s) - LW'(pop_s);
        // The slot being written this cycle becomes the head when it is
        // where the read pointer lands, so take the incoming byte directly.
        if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = wr_data;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Byte storage; no reset needed because the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, occupancy, flags and head register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            wr_ready_r <= 1'b0;
            rd_valid_r <= 1'b0;
            head_r     <= 8'h00;
        end else if (srst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            level_r    <= '0;
            wr_ready_r <= 1'b0;
            rd_valid_r <= 1'b0;
            head_r     <= 8'h00;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            level_r    <= level_nxt_s;
            wr_ready_r <= (level_nxt_s != LW'(DEPTH));
            rd_valid_r <= (level_nxt_s != '0);
            head_r     <= head_nxt_s;
        end
    end

    assign wr_ready = wr_ready_r;
    assign rd_valid = rd_valid_r;
    assign rd_data  = head_r;
    assign level    = level_r;
endmodule

// Top level: pins, core, FIFOs and drop counter.
module usb_uart_fifo_i40 #(
    parameter int IN_DEPTH  = 16,
    parameter int OUT_DEPTH = 16,
    parameter int OUT_DROP  = 0
) (
    input  logic                        clk_48mhz,
    input  logic                        reset_n,
    inout  wire                         pin_usb_p,
    inout  wire                         pin_usb_n,
    input  logic [7:0]                  uart_in_data,
    input  logic                        uart_in_valid,
    output logic                        uart_in_ready,
    output logic [7:0]                  uart_out_data,
    output logic                        uart_out_valid,
    input  logic                        uart_out_ready,
    output logic [$clog2(IN_DEPTH):0]   in_level,
    output logic [$clog2(OUT_DEPTH):0]  out_level,
    output logic [7:0]                  out_drop_count,
    output logic [11:0]                 debug
);
    logic [1:0]  sync_r;
    logic        core_reset_s;
    logic        usb_p_tx_s;
    logic        usb_n_tx_s;
    logic        usb_p_in_s;
    logic        usb_n_in_s;
    logic        usb_p_rx_s;
    logic        usb_n_rx_s;
    logic        usb_tx_en_s;
    logic [7:0]  core_in_data_s;
    logic        core_in_valid_s;
    logic        core_in_ready_s;
    logic [7:0]  core_out_data_s;
    logic        core_out_valid_s;
    logic        core_out_ready_s;
    logic        out_wr_ready_s;
    logic [11:0] core_debug_s;
    logic        drop_s;
    logic [7:0]  drop_count_r;

    // Reset synchroniser: immediate assertion, release two edges after reset_n rises.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], 1'b1};
        end
    end

    assign core_reset_s = ~sync_r[1];

    SB_IO #(
        .PIN_TYPE (6'b101001)
    ) u_io_p (
        .PACKAGE_PIN   (pin_usb_p),
        .OUTPUT_ENABLE (usb_tx_en_s),
        .D_OUT_0       (usb_p_tx_s),
        .D_IN_0        (usb_p_in_s)
    );

    SB_IO #(
        .PIN_TYPE (6'b101001)
    ) u_io_n (
        .PACKAGE_PIN   (pin_usb_n),
        .OUTPUT_ENABLE (usb_tx_en_s),
        .D_OUT_0       (usb_n_tx_s),
        .D_IN_0        (usb_n_in_s)
    );

    // While transmitting, the receiver sees an idle J state instead of its own echo.
    always_comb begin
        usb_p_rx_s = usb_p_in_s;
        usb_n_rx_s = usb_n_in_s;
        if (usb_tx_en_s) begin
            usb_p_rx_s = 1'b1;
            usb_n_rx_s = 1'b0;
        end else begin
            usb_p_rx_s = usb_p_in_s;
            usb_n_rx_s = usb_n_in_s;
        end
    end

    usb_uart u_core (
        .clk_48mhz      (clk_48mhz),
        .reset          (core_reset_s),
        .usb_p_tx       (usb_p_tx_s),
        .usb_n_tx       (usb_n_tx_s),
        .usb_p_rx       (usb_p_rx_s),
        .usb_n_rx       (usb_n_rx_s),
        .usb_tx_en      (usb_tx_en_s),
        .uart_in_data   (core_in_data_s),
        .uart_in_valid  (core_in_valid_s),
        .uart_in_ready  (core_in_ready_s),
        .uart_out_data  (core_out_data_s),
        .uart_out_valid (core_out_valid_s),
        .uart_out_ready (core_out_ready_s),
        .debug          (core_debug_s)
    );

    // Device-to-host: user logic writes, the core drains.
    usb_uart_fifo_i40_fifo #(
        .DEPTH (IN_DEPTH)
    ) u_in_fifo (
        .clk      (clk_48mhz),
        .rst_n    (reset_n),
        .srst     (core_reset_s),
        .wr_data  (uart_in_data),
        .wr_valid (uart_in_valid),
        .wr_ready (uart_in_ready),
        .rd_data  (core_in_data_s),
        .rd_valid (core_in_valid_s),
        .rd_ready (core_in_ready_s),
        .level    (in_level)
    );

    // Host-to-device: the core writes, user logic drains.
    usb_uart_fifo_i40_fifo #(
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clk      (clk_48mhz),
        .rst_n    (reset_n),
        .srst     (core_reset_s),
        .wr_data  (core_out_data_s),
        .wr_valid (core_out_valid_s),
        .wr_ready (out_wr_ready_s),
        .rd_data  (uart_out_data),
        .rd_valid (uart_out_valid),
        .rd_ready (uart_out_ready),
        .level    (out_level)
    );

    // In drop mode the core is never stalled; a byte offered while full is lost.
    assign core_out_ready_s = (OUT_DROP != 32'sd0) ? 1'b1 : out_wr_ready_s;
    assign drop_s = (OUT_DROP != 32'sd0) & core_out_valid_s & ~out_wr_ready_s & ~core_reset_s;

    // Saturating count of discarded host-to-device bytes.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            drop_count_r <= 8'h00;
        end else if (core_reset_s) begin
            drop_count_r <= 8'h00;
        end else if (drop_s && (drop_count_r != 8'hFF)) begin
            drop_count_r <= drop_count_r + 8'h01;
        end else begin
            drop_count_r <= drop_count_r;
        end
    end

    assign out_drop_count = drop_count_r;
    assign debug          = core_debug_s;
endmodule

// File: tb/tb_usb_uart_fifo_i40.sv
// Directed bench for usb_uart_fifo_i40: one instance back-pressures the core,
// a second runs in drop mode. Core-side handshakes are forced on the wrapper
// nets that connect to the core.
module tb_usb_uart_fifo_i40;
    logic        clk = 1'b0;
    logic        reset_n;
    wire         pin_p;
    wire         pin_n;
    wire         pin_dp;
    wire         pin_dn;
    logic        drv_en;
    logic        drv_p;
    logic        drv_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_d;
    logic [7:0]  out_data;
    logic [7:0]  out_data_d;
    logic        out_valid;
    logic        out_valid_d;
    logic        out_ready;
    logic [4:0]  in_level;
    logic [4:0]  in_level_d;
    logic [4:0]  out_level;
    logic [4:0]  out_level_d;
    logic [7:0]  drop_cnt;
    logic [7:0]  drop_cnt_d;
    logic [11:0] debug;
    logic [11:0] debug_d;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [4:0] exp_level;
        logic       exp_ready;
    } vec_t;

    vec_t tbl [17];

    assign pin_p  = drv_en ? drv_p : 1'bz;
    assign pin_n  = drv_en ? drv_n : 1'bz;
    assign pin_dp = drv_en ? drv_p : 1'bz;
    assign pin_dn = drv_en ? drv_n : 1'bz;

    always #10 clk = ~clk;

    usb_uart_fifo_i40 #(.IN_DEPTH(16), .OUT_DEPTH(16), .OUT_DROP(0)) dut (
        .clk_48mhz      (clk),
        .reset_n        (reset_n),
        .pin_usb_p      (pin_p),
        .pin_usb_n      (pin_n),
        .uart_in_data   (in_data),
        .uart_in_valid  (in_valid),
        .uart_in_ready  (in_ready),
        .uart_out_data  (out_data),
        .uart_out_valid (out_valid),
        .uart_out_ready (out_ready),
        .in_level       (in_level),
        .out_level      (out_level),
        .out_drop_count (drop_cnt),
        .debug          (debug)
    );

    usb_uart_fifo_i40 #(.IN_DEPTH(16), .OUT_DEPTH(16), .OUT_DROP(1)) dut_d (
        .clk_48mhz      (clk),
        .reset_n        (reset_n),
        .pin_usb_p      (pin_dp),
        .pin_usb_n      (pin_dn),
        .uart_in_data   (8'h00),
        .uart_in_valid  (1'b0),
        .uart_in_ready  (in_ready_d),
        .uart_out_data  (out_data_d),
        .uart_out_valid (out_valid_d),
        .uart_out_ready (out_ready),
        .in_level       (in_level_d),
        .out_level      (out_level_d),
        .out_drop_count (drop_cnt_d),
        .debug          (debug_d)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] v;
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       acc0;
        logic       acc1;
        int         idx0;
        int         idx1;
        int         rx0;
        int         rx1;

        // Device-to-host fill: 16 bytes fit, the 17th is refused.
        for (int i = 0; i < 17; i++) begin
            tbl[i].valid     = 1'b1;
            tbl[i].data      = 8'(i);
            tbl[i].exp_level = (i < 16) ? 5'(i + 1) : 5'd16;
            tbl[i].exp_ready = (i < 15) ? 1'b1 : 1'b0;
        end

        reset_n   = 1'b0;
        drv_en    = 1'b1;
        drv_p     = 1'b1;
        drv_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // ---------------- reset ----------------
        repeat (10) tick();
        check("rst in_level", 32'(in_level), 32'd0);
        check("rst out_level", 32'(out_level), 32'd0);
        check("rst drop_count", 32'(drop_cnt), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_data", 32'(out_data), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst tx_en", 32'(dut.usb_tx_en_s), 32'd0);
        reset_n = 1'b1;
        tick();
        check("rel edge1 in_ready", 32'(in_ready), 32'd0);
        tick();
        check("rel edge2 in_ready", 32'(in_ready), 32'd0);
        tick();
        check("rel edge3 in_ready", 32'(in_ready), 32'd1);
        check("rel edge3 in_ready drop", 32'(in_ready_d), 32'd1);
        check("rel tx_en", 32'(dut.usb_tx_en_s), 32'd0);

        // ---------------- in FIFO fill, core stalled ----------------
        force dut.core_in_ready_s = 1'b0;
        for (int i = 0; i < 17; i++) begin
            in_valid = tbl[i].valid;
            in_data  = tbl[i].data;
            tick();
            check("fill in_level", 32'(in_level), 32'(tbl[i].exp_level));
            check("fill in_ready", 32'(in_ready), 32'(tbl[i].exp_ready));
        end
        in_valid = 1'b0;
        check("full core head", 32'(dut.core_in_data_s), 32'h00);

        force dut.core_in_ready_s = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("pull valid", 32'(dut.core_in_valid_s), 32'd1);
            check("pull data", 32'(dut.core_in_data_s), 32'(i));
            tick();
            if (i == 0) begin
                check("full pop in_ready", 32'(in_ready), 32'd1);
            end
        end
        force dut.core_in_ready_s = 1'b0;
        check("drained in_level", 32'(in_level), 32'd0);
        check("drained core valid", 32'(dut.core_in_valid_s), 32'd0);

        // ---------------- out FIFO: back-pressure vs drop ----------------
        idx0 = 0;
        idx1 = 0;
        rx0  = 0;
        rx1  = 0;
        for (int c = 0; c < 65; c++) begin
            if (c == 25) begin
                check("stall out_level", 32'(out_level), 32'd16);
                check("stall out_level drop", 32'(out_level_d), 32'd16);
                check("stall core ready", 32'(dut.core_out_ready_s), 32'd0);
                check("stall core ready drop", 32'(dut_d.core_out_ready_s), 32'd1);
                check("stall accepted", 32'(idx0), 32'd16);
                check("stall drop_count", 32'(drop_cnt), 32'd0);
                check("stall drop_count drop", 32'(drop_cnt_d), 32'd4);
                check("stall head", 32'(out_data), 32'h40);
                check("stall head drop", 32'(out_data_d), 32'h40);
                out_ready = 1'b1;
            end
            v0 = (idx0 < 20);
            d0 = 8'h40 + 8'(idx0);
            v1 = (idx1 < 20);
            d1 = 8'h40 + 8'(idx1);
            force dut.core_out_valid_s   = v0;
            force dut.core_out_data_s    = d0;
            force dut_d.core_out_valid_s = v1;
            force dut_d.core_out_data_s  = d1;
            acc0 = v0 & dut.core_out_ready_s;
            acc1 = v1 & dut_d.core_out_ready_s;
            if (out_ready && out_valid) begin
                check("out data", 32'(out_data), 32'h40 + 32'(rx0));
                rx0++;
            end
            if (out_ready && out_valid_d) begin
                check("out data drop", 32'(out_data_d), 32'h40 + 32'(rx1));
                rx1++;
            end
            tick();
            if (acc0) idx0++;
            if (acc1) idx1++;
        end
        force dut.core_out_valid_s   = 1'b0;
        force dut_d.core_out_valid_s = 1'b0;
        out_ready = 1'b0;
        check("out received", 32'(rx0), 32'd20);
        check("out received drop", 32'(rx1), 32'd16);
        check("out final level", 32'(out_level), 32'd0);
        check("out final level drop", 32'(out_level_d), 32'd0);
        check("out final valid", 32'(out_valid), 32'd0);
        check("out final drop_count", 32'(drop_cnt_d), 32'd4);

        // ---------------- simultaneous push/pop at level 8 ----------------
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h80 + 8'(k);
            q.push_back(in_data);
            tick();
        end
        in_valid = 1'b0;
        check("pre level 8", 32'(in_level), 32'd8);
        force dut.core_in_ready_s = 1'b1;
        for (int c = 0; c < 100; c++) begin
            v        = 8'h88 + 8'(c);
            in_valid = 1'b1;
            in_data  = v;
            check("sim head", 32'(dut.core_in_data_s), 32'(q.pop_front()));
            q.push_back(v);
            tick();
            check("sim level", 32'(in_level), 32'd8);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("trim head", 32'(dut.core_in_data_s), 32'(q.pop_front()));
            tick();
        end
        force dut.core_in_ready_s = 1'b0;
        check("level 5", 32'(in_level), 32'd5);

        // ---------------- receive path while transmitting ----------------
        drv_p = 1'b0;
        drv_n = 1'b1;
        #1;
        check("rx raw p", 32'(dut.usb_p_rx_s), 32'd0);
        check("rx raw n", 32'(dut.usb_n_rx_s), 32'd1);
        force dut.usb_tx_en_s = 1'b1;
        #1;
        check("rx J p", 32'(dut.usb_p_rx_s), 32'd1);
        check("rx J n", 32'(dut.usb_n_rx_s), 32'd0);
        tick();
        check("debug rx J", 32'(debug[11:10]), 32'h2);

        // ---------------- reset mid-packet ----------------
        release dut.usb_tx_en_s;
        reset_n = 1'b0;
        #1;
        check("mid rst in_level", 32'(in_level), 32'd0);
        check("mid rst out_level", 32'(out_level), 32'd0);
        check("mid rst in_ready", 32'(in_ready), 32'd0);
        check("mid rst core valid", 32'(dut.core_in_valid_s), 32'd0);
        check("mid rst core reset", 32'(dut.core_reset_s), 32'd1);
        check("mid rst tx_en", 32'(dut.usb_tx_en_s), 32'd0);
        check("mid rst drop_count", 32'(drop_cnt_d), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("post rst in_ready", 32'(in_ready), 32'd1);
        check("post rst in_level", 32'(in_level), 32'd0);
        check("post rst core valid", 32'(dut.core_in_valid_s), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
